spi_slave_byte: RTL and testbench
=================================

// Module: spi_slave_byte
// PURPOSE
//  Byte-oriented SPI slave: the responder end of the link driven by the SPI master block.
//  Oversamples sclk/n_cs/mosi in the sys_clk domain, shifts bytes MSB-first, and pushes each
//  received byte to an RX FIFO write port. Pops TX bytes from a show-ahead FIFO read port onto miso.
//  Used on test fixtures and loopback paths that emulate an SPI peripheral.
// PARAMETERS
//  CPOL             1'b0  idle level of sclk
//  CPHA             1'b0  0: sample on leading edge, shift on trailing edge; 1: shift on leading, sample on trailing
//  BYTES_PER_FRAME  8'd2  expected bytes per n_cs-low window (>=1)
//  DUMMY_BYTE       8'hFF byte transmitted when TX FIFO is empty at a byte load
// PORTS
//  sys_clk    in   1  single clock; must be >= 8x sclk frequency
//  rst        in   1  synchronous reset, active-high
//  sclk       in   1  SPI clock from master (asynchronous)
//  n_cs       in   1  chip select from master, active-low (asynchronous)
//  mosi       in   1  serial data from master (asynchronous)
//  miso       out  1  serial data to master; tx_reg[7]
//  miso_oe    out  1  miso drive enable = armed & n_cs_sync low
//  tx_data    in   8  show-ahead TX FIFO output, valid while !tx_empty
//  tx_empty   in   1  TX FIFO empty
//  tx_rdreq   out  1  one-cycle pop of TX FIFO
//  rx_data    out  8  received byte, valid with rx_wrreq
//  rx_wrreq   out  1  one-cycle write strobe to RX FIFO
//  frame_done out  1  one-cycle pulse: n_cs rose after exactly BYTES_PER_FRAME whole bytes
//  frame_err  out  1  one-cycle pulse: n_cs rose with partial byte or wrong byte count
//  busy       out  1  high from LOAD entry until return to IDLE
// BEHAVIOUR
//  - Reset: all outputs 0 except miso=DUMMY_BYTE[7]; state=WAIT_HI; counters 0; sync regs = idle values (sclk=CPOL, n_cs=1).
//  - Sync: 2-FF synchronizers on sclk, n_cs, mosi; sclk edges from the synced value vs. a 3rd register.
//    Input-to-action latency: 3 sys_clk.
//  - Sample edge = leading if CPHA=0 else trailing; leading = rising if CPOL=0, falling if CPOL=1.
//  - FSM:
//    WAIT_HI: wait for n_cs_sync=1, then -> IDLE. Entered after reset, so a frame in progress at reset is ignored.
//    IDLE: on n_cs_sync fall -> LOAD.
//    LOAD: 1 cycle. If !tx_empty: tx_reg<=tx_data, tx_rdreq=1; else tx_reg<=DUMMY_BYTE. bit_cnt<=0. -> SHIFT.
//    SHIFT:
//      - On sample edge: rx_sh<={rx_sh[6:0],mosi_sync}; bit_cnt++.
//      - On shift edge: tx_reg<={tx_reg[6:0],1'b0}. CPHA=0 ignores the first shift edge after LOAD... no: CPHA=0 shifts
//        on every trailing edge except the one ending the 8th bit, which triggers the reload instead.
//        CPHA=1 ignores shift edges until after LOAD.
//      - After 8th sample edge: rx_data<=rx_sh_next, rx_wrreq=1 next cycle; byte_cnt++ (saturates at 255).
//        For CPHA=0 -> LOAD immediately. For CPHA=1 -> LOAD before the next leading edge.
//      - On n_cs_sync rise (any state except WAIT_HI): -> IDLE.
//        frame_done=1 if bit_cnt==0 && byte_cnt==BYTES_PER_FRAME; else frame_err=1.
//        Partial byte is discarded (no rx_wrreq); byte_cnt<=0.
//    LOAD with n_cs rise on the same cycle: rise wins; no tx_rdreq issued.
//  - Extra bytes beyond BYTES_PER_FRAME are still received and written to RX; frame_err at n_cs rise.
//  - rx_wrreq is never gated by a full flag; the RX FIFO must be sized by the system.
//  - sclk edges while n_cs_sync=1 are ignored.
//  - rst mid-frame: returns to WAIT_HI within 1 cycle; no strobes until the next full frame.
// STRUCTURE
//  - spi_defs.vh (shared with the master): FSM state localparams WAIT_HI/IDLE/LOAD/SHIFT,
//    and the edge-select helper expressions for CPOL/CPHA.
//  - Sub-module spi_sync_edge: N-FF synchronizer plus rise/fall detect, instantiated for sclk, n_cs and mosi.
//  - Top holds the FSM, shift registers, bit_cnt (3b) and byte_cnt (8b).
//  - Target size: ~200 lines.
// TESTING
//  1. CPOL=0, CPHA=0, sys_clk:sclk=10:1. TX FIFO={8'hA5,8'h3C}; master sends 8'h12,8'h34.
//     -> rx_wrreq x2 with 8'h12, 8'h34; master reads 8'hA5, 8'h3C; frame_done=1 once.
//  2. Modes 1, 2 and 3 with the same bytes -> identical rx/tx results.
//     tx_rdreq count is 2 and occurs only in LOAD.
//  3. TX FIFO empty -> miso carries 8'hFF per byte; tx_rdreq never asserted.
//  4. n_cs rises after 13 bits -> exactly one rx_wrreq (first byte); frame_err=1, frame_done=0; busy=0 within 4 cycles.
//  5. Master sends 3 bytes with BYTES_PER_FRAME=2 -> 3 rx_wrreq, frame_err=1.
//  6. rst asserted mid-frame, deasserted while n_cs is still low -> no rx_wrreq for that frame;
//     the next full frame is handled normally.

Source files
------------

// File: rtl/spi_slave_byte_pkg.sv
// Shared definitions for the byte-oriented SPI slave: FSM states and the
// CPOL/CPHA edge-selection helpers.
package spi_slave_byte_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_HI = 2'd0,
    ST_IDLE    = 2'd1,
    ST_LOAD    = 2'd2,
    ST_SHIFT   = 2'd3
  } state_t;

  localparam int         SYNC_STAGES = 2;
  // n_cs must read high this many consecutive cycles before leaving WAIT_HI,
  // so the idle reset value still sitting in the synchronizer is not trusted.
  localparam logic [1:0] SETTLE_MAX  = 2'd3;

  function automatic logic sample_edge(input logic cpol, input logic cpha,
                                       input logic rise, input logic fall);
    logic lead;
    logic trail;
    lead  = cpol ? fall : rise;
    trail = cpol ? rise : fall;
    return cpha ? trail : lead;
  endfunction

  function automatic logic shift_edge(input logic cpol, input logic cpha,
                                      input logic rise, input logic fall);
    logic lead;
    logic trail;
    lead  = cpol ? fall : rise;
    trail = cpol ? rise : fall;
    return cpha ? lead : trail;
  endfunction

endpackage

// File: rtl/spi_slave_byte_sync_edge.sv
// N-stage synchronizer for an asynchronous input with rise/fall detection
// against one extra history register.
module spi_slave_byte_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_pipe;
  logic              r_prev;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pipe <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_pipe <= {r_pipe[STAGES-2:0], i_async};
      r_prev <= r_pipe[STAGES-1];
    end
  end

  assign o_sync = r_pipe[STAGES-1];
  assign o_rise = r_pipe[STAGES-1] & ~r_prev;
  assign o_fall = ~r_pipe[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_byte.sv
// Byte-oriented SPI slave: oversamples the SPI pins in the sys_clk domain,
// shifts bytes MSB-first, writes RX bytes to a FIFO and pops TX bytes onto miso.
module spi_slave_byte
  import spi_slave_byte_pkg::*;
#(
  parameter logic       CPOL            = 1'b0,
  parameter logic       CPHA            = 1'b0,
  parameter logic [7:0] BYTES_PER_FRAME = 8'd2,
  parameter logic [7:0] DUMMY_BYTE      = 8'hFF
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       n_cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_rdreq,
  output logic [7:0] rx_data,
  output logic       rx_wrreq,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  logic w_sclk_rise, w_sclk_fall, w_unused_sclk_lvl;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_mosi_sync, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_slave_byte_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .sys_clk(sys_clk), .rst(rst), .i_async(sclk),
    .o_sync(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_slave_byte_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .sys_clk(sys_clk), .rst(rst), .i_async(n_cs),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_slave_byte_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .sys_clk(sys_clk), .rst(rst), .i_async(mosi),
    .o_sync(w_mosi_sync), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  state_t     r_state;
  logic [1:0] r_settle;
  logic [7:0] r_tx;
  logic [7:0] r_rx_sh;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_rx_data;
  logic       r_rx_wrreq;
  logic       r_frame_done;
  logic       r_frame_err;
  logic       r_busy;

  logic       w_sample;
  logic       w_shift;
  logic [7:0] w_rx_sh_next;

  assign w_sample     = sample_edge(CPOL, CPHA, w_sclk_rise, w_sclk_fall) & ~w_cs_sync;
  assign w_shift      = shift_edge(CPOL, CPHA, w_sclk_rise, w_sclk_fall) & ~w_cs_sync;
  assign w_rx_sh_next = {r_rx_sh[6:0], w_mosi_sync};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= ST_WAIT_HI;
      r_settle     <= 2'd0;
      r_tx         <= DUMMY_BYTE;
      r_rx_sh      <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= 8'd0;
      r_rx_data    <= 8'd0;
      r_rx_wrreq   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_wrreq   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state != ST_WAIT_HI && w_cs_rise) begin
        // End of window: a partial byte is dropped silently.
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 8'd0;
        if (r_bit_cnt == 3'd0 && r_byte_cnt == BYTES_PER_FRAME) r_frame_done <= 1'b1;
        else                                                     r_frame_err  <= 1'b1;
      end else begin
        case (r_state)
          ST_WAIT_HI: begin
            if (w_cs_sync) begin
              if (r_settle == SETTLE_MAX) r_state  <= ST_IDLE;
              else                        r_settle <= r_settle + 2'd1;
            end else begin
              r_settle <= 2'd0;
            end
          end
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state    <= ST_LOAD;
              r_busy     <= 1'b1;
              r_byte_cnt <= 8'd0;
            end
          end
          ST_LOAD: begin
            r_tx      <= tx_empty ? DUMMY_BYTE : tx_data;
            r_bit_cnt <= 3'd0;
            r_state   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            // The first shift edge of each byte is skipped: the MSB is already on miso.
            if (w_shift && r_bit_cnt != 3'd0) r_tx <= {r_tx[6:0], 1'b0};
            if (w_sample) begin
              r_rx_sh   <= w_rx_sh_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_rx_data  <= w_rx_sh_next;
                r_rx_wrreq <= 1'b1;
                if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
                r_state    <= ST_LOAD;
              end
            end
          end
          default: r_state <= ST_WAIT_HI;
        endcase
      end
    end
  end

  // Pop handshake is decoded from LOAD so it coincides with the tx_data capture.
  assign tx_rdreq   = (r_state == ST_LOAD) && !tx_empty && !w_cs_rise;
  assign miso       = r_tx[7];
  assign miso_oe    = r_busy & ~w_cs_sync;
  assign rx_data    = r_rx_data;
  assign rx_wrreq   = r_rx_wrreq;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Scoreboard bench for spi_slave_byte: one DUT per SPI mode, a behavioural
// master, a TX FIFO model, and a monitor that pops expected results.
module tb_spi_slave_byte;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [3:0] sclk_a  = 4'b1100;
  logic [3:0] ncs_a   = 4'b1111;
  logic [3:0] mosi_a  = 4'b0000;
  logic [7:0] tb_tx_data  = 8'h00;
  logic       tb_tx_empty = 1'b1;
  int         cur_mode    = 0;

  wire [3:0] miso_a, miso_oe_a, tx_empty_a, tx_rdreq_a, rx_wrreq_a;
  wire [3:0] done_a, err_a, busy_a;
  wire [7:0] rx_data_a [4];

  logic [7:0] tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] got_miso_q[$];
  logic [1:0] exp_frame_q[$];

  int  checks    = 0;
  int  errors    = 0;
  int  rdreq_cnt = 0;
  bit  pend_pop  = 1'b0;

  always #5 sys_clk = ~sys_clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam logic [1:0] MODE = 2'(gi);
    assign tx_empty_a[gi] = (cur_mode == gi) ? tb_tx_empty : 1'b1;
    spi_slave_byte #(
      .CPOL(MODE[1]), .CPHA(MODE[0]), .BYTES_PER_FRAME(8'd2), .DUMMY_BYTE(8'hFF)
    ) u_dut (
      .sys_clk(sys_clk), .rst(rst), .sclk(sclk_a[gi]), .n_cs(ncs_a[gi]),
      .mosi(mosi_a[gi]), .miso(miso_a[gi]), .miso_oe(miso_oe_a[gi]),
      .tx_data(tb_tx_data), .tx_empty(tx_empty_a[gi]), .tx_rdreq(tx_rdreq_a[gi]),
      .rx_data(rx_data_a[gi]), .rx_wrreq(rx_wrreq_a[gi]),
      .frame_done(done_a[gi]), .frame_err(err_a[gi]), .busy(busy_a[gi])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s mode=%0d got=%0h required=%0h", name, cur_mode, got, exp);
    end
  endtask

  // Scoreboard monitor and TX FIFO model (pop applied one cycle after the strobe).
  task automatic monitor();
    logic [7:0] g;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        pend_pop = 1'b0;
      end else begin
        if (pend_pop) begin
          if (tx_q.size() > 0) void'(tx_q.pop_front());
          pend_pop = 1'b0;
        end
        if (tx_rdreq_a[cur_mode]) begin
          rdreq_cnt++;
          pend_pop = 1'b1;
        end
        if (rx_wrreq_a[cur_mode]) begin
          $display("rx   mode=%0d byte=%02h", cur_mode, rx_data_a[cur_mode]);
          if (exp_rx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_unexpected mode=%0d got=%02h required=none", cur_mode, rx_data_a[cur_mode]);
          end else chk("rx_data", 32'(rx_data_a[cur_mode]), 32'(exp_rx_q.pop_front()));
        end
        if (done_a[cur_mode] || err_a[cur_mode]) begin
          $display("frm  mode=%0d done=%0b err=%0b", cur_mode, done_a[cur_mode], err_a[cur_mode]);
          if (exp_frame_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_unexpected mode=%0d got=%0b%0b required=none",
                     cur_mode, err_a[cur_mode], done_a[cur_mode]);
          end else chk("frame_{err,done}", 32'({err_a[cur_mode], done_a[cur_mode]}),
                       32'(exp_frame_q.pop_front()));
        end
        while (got_miso_q.size() > 0) begin
          g = got_miso_q.pop_front();
          $display("miso mode=%0d byte=%02h", cur_mode, g);
          if (exp_miso_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL miso_unexpected mode=%0d got=%02h required=none", cur_mode, g);
          end else chk("miso_byte", 32'(g), 32'(exp_miso_q.pop_front()));
        end
        tb_tx_empty = (tx_q.size() == 0);
        tb_tx_data  = tb_tx_empty ? 8'h00 : tx_q[0];
      end
    end
  endtask

  task automatic half_period();
    repeat (5) @(negedge sys_clk);
  endtask

  // SPI master: sclk is 10 sys_clk per period.
  task automatic run_frame(input int m, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int nbits,
                           input bit chk_miso, input bit chk_busy);
    logic [7:0] tx_b [3];
    logic [1:0] md;
    logic       cpol, cpha, bitv;
    logic [7:0] rxb;
    tx_b = '{b0, b1, b2};
    md   = m[1:0];
    cpol = md[1];
    cpha = md[0];
    rxb  = 8'h00;
    cur_mode = m;
    @(negedge sys_clk);
    ncs_a[m] = 1'b0;
    repeat (10) @(negedge sys_clk);
    if (chk_busy) begin
      chk("busy_in_frame", 32'(busy_a[m]), 32'd1);
      chk("miso_oe_in_frame", 32'(miso_oe_a[m]), 32'd1);
    end
    for (int i = 0; i < nbits; i++) begin
      bitv = tx_b[i/8][7-(i%8)];
      if (!cpha) begin
        mosi_a[m] = bitv;
        half_period();
        sclk_a[m] = ~cpol;
        rxb = {rxb[6:0], miso_a[m]};
        half_period();
        sclk_a[m] = cpol;
      end else begin
        sclk_a[m] = ~cpol;
        mosi_a[m] = bitv;
        half_period();
        sclk_a[m] = cpol;
        rxb = {rxb[6:0], miso_a[m]};
        half_period();
      end
      if (i % 8 == 7 && chk_miso) got_miso_q.push_back(rxb);
    end
    if (!cpha) half_period();
    if (chk_busy) chk("busy_before_rise", 32'(busy_a[m]), 32'd1);
    ncs_a[m] = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("busy_after_rise", 32'(busy_a[m]), 32'd0);
    chk("miso_oe_after_rise", 32'(miso_oe_a[m]), 32'd0);
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic end_test(input int exp_rdreq);
    repeat (5) @(negedge sys_clk);
    chk("rx_missing", 32'(exp_rx_q.size()), 32'd0);
    chk("frame_missing", 32'(exp_frame_q.size()), 32'd0);
    chk("miso_missing", 32'(exp_miso_q.size()), 32'd0);
    chk("tx_rdreq_count", 32'(rdreq_cnt), 32'(exp_rdreq));
    chk("tx_fifo_left", 32'(tx_q.size()), 32'd0);
    exp_rx_q.delete(); exp_frame_q.delete(); exp_miso_q.delete(); tx_q.delete();
    rdreq_cnt = 0;
  endtask

  task automatic std_frame(input int m, input logic [7:0] ta, input logic [7:0] tb_,
                           input logic [7:0] ra, input logic [7:0] rb);
    tx_q.push_back(ta);        tx_q.push_back(tb_);
    exp_rx_q.push_back(ra);    exp_rx_q.push_back(rb);
    exp_miso_q.push_back(ta);  exp_miso_q.push_back(tb_);
    exp_frame_q.push_back(2'b01);
    repeat (2) @(negedge sys_clk);
    run_frame(m, ra, rb, 8'h00, 16, 1'b1, 1'b1);
    end_test(2);
  endtask

  initial begin
    repeat (50000) @(posedge sys_clk);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    repeat (5) @(negedge sys_clk);
    chk("rst_miso", 32'(miso_a), 32'hF);
    chk("rst_miso_oe", 32'(miso_oe_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_rx_wrreq", 32'(rx_wrreq_a), 32'h0);
    chk("rst_frame", 32'({done_a, err_a}), 32'h0);
    chk("rst_tx_rdreq", 32'(tx_rdreq_a), 32'h0);
    chk("rst_rx_data", 32'(rx_data_a[0]), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge sys_clk);

    // Basic mode 0 transfer, then the other three modes with the same bytes.
    std_frame(0, 8'hA5, 8'h3C, 8'h12, 8'h34);
    for (int m = 1; m < 4; m++) std_frame(m, 8'hA5, 8'h3C, 8'h12, 8'h34);

    // Empty TX FIFO: dummy bytes, no pops.
    exp_rx_q.push_back(8'h12);   exp_rx_q.push_back(8'h34);
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'hFF);
    exp_frame_q.push_back(2'b01);
    run_frame(0, 8'h12, 8'h34, 8'h00, 16, 1'b1, 1'b1);
    end_test(0);

    // Window closes after 13 bits: first byte kept, partial dropped.
    tx_q.push_back(8'hA5);     tx_q.push_back(8'h3C);
    exp_rx_q.push_back(8'h12);
    exp_miso_q.push_back(8'hA5);
    exp_frame_q.push_back(2'b10);
    repeat (2) @(negedge sys_clk);
    run_frame(0, 8'h12, 8'h34, 8'h00, 13, 1'b1, 1'b1);
    end_test(2);

    // Three bytes into a two-byte frame, mode 3.
    tx_q.push_back(8'hA5);     tx_q.push_back(8'h3C);
    exp_rx_q.push_back(8'h12); exp_rx_q.push_back(8'h34); exp_rx_q.push_back(8'h56);
    exp_miso_q.push_back(8'hA5); exp_miso_q.push_back(8'h3C); exp_miso_q.push_back(8'hFF);
    exp_frame_q.push_back(2'b10);
    repeat (2) @(negedge sys_clk);
    run_frame(3, 8'h12, 8'h34, 8'h56, 24, 1'b1, 1'b1);
    end_test(2);

    // Reset pulse in mid-frame: the rest of that frame must produce nothing.
    fork
      run_frame(0, 8'h12, 8'h34, 8'h00, 16, 1'b0, 1'b0);
      begin
        repeat (60) @(negedge sys_clk);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
      end
    join
    end_test(0);
    std_frame(0, 8'h5A, 8'hC3, 8'h9A, 8'hBC);
    std_frame(2, 8'h81, 8'h7E, 8'h01, 8'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
